// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles needed to cover the full operand width.
    function automatic int num_digits(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end else begin
            return width / digit;
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// One DIGIT-wide ripple of full-subtract cells; purely combinational.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             br_in,
    output logic [DIGIT-1:0] diff_d,
    output logic             br_out
);

    logic [DIGIT:0] w_br;

    assign w_br[0] = br_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign diff_d[i]  = a_d[i] ^ b_d[i] ^ w_br[i];
        assign w_br[i+1]  = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & w_br[i]);
    end

    assign br_out = w_br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - Bin with valid/ready on both sides, borrow-out and signed overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_param_check
        $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic [BW-1:0]    w_base;
    logic [DIGIT-1:0] w_a_d;
    logic [DIGIT-1:0] w_b_d;
    logic [DIGIT-1:0] w_diff_d;
    logic             w_br_out;

    // One shared digit slice, steered by the digit counter.
    assign w_base = BW'(int'(r_k) * DIGIT);
    assign w_a_d  = r_a[w_base +: DIGIT];
    assign w_b_d  = r_b[w_base +: DIGIT];

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .a_d    (w_a_d),
        .b_d    (w_b_d),
        .br_in  (r_br),
        .diff_d (w_diff_d),
        .br_out (w_br_out)
    );

    // Control FSM plus operand, borrow and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_k     <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_diff[w_base +: DIGIT] <= w_diff_d;
                    r_br                    <= w_br_out;
                    if (r_k == K_LAST) begin
                        r_bout  <= w_br_out;
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_diff_d[DIGIT-1] != r_a[WIDTH-1]);
                        r_k     <= '0;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_k     <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && rst_n;
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: 16-bit/4-bit-digit instance plus an 8-bit single-digit instance.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
    logic [15:0] a, b, diff;

    logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb8_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, independent of the digit ripple.
    function automatic exp_t model16(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        exp_t       e;
        logic [16:0] full;
        full   = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        e.diff = full[15:0];
        e.bout = ({1'b0, ma} < ({1'b0, mb} + {16'd0, mbin}));
        e.ovf  = (ma[15] != mb[15]) && (e.diff[15] != ma[15]);
        return e;
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          input int hold, input bit poke_busy);
        int   lat;
        exp_t e;
        @(negedge clk);
        check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        sb_q.push_back(model16(ta, tb, tbin));
        @(posedge clk);
        @(negedge clk);
        if (poke_busy) begin
            a = ~ta; b = 16'h1111; bin = ~tbin;
        end else begin
            in_valid = 1'b0;
            a = $urandom; b = $urandom;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat == 1) begin
                check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, 32'd4);
        if (sb_q.size() == 0) begin
            check_eq("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("diff", {16'd0, diff}, {16'd0, e.diff});
            check_eq("bout", {31'd0, bout}, {31'd0, e.bout});
            check_eq("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
                check_eq("hold_ready", {31'd0, in_ready},  32'd0);
                check_eq("hold_diff",  {16'd0, diff},      {16'd0, e.diff});
                check_eq("hold_flags", {30'd0, bout, ovf}, {30'd0, e.bout, e.ovf});
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("consumed_valid", {31'd0, out_valid}, 32'd0);
            check_eq("consumed_ready", {31'd0, in_ready},  32'd1);
            check_eq("consumed_diff",  {16'd0, diff},      {16'd0, e.diff});
        end
    endtask

    initial begin
        exp_t e8;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_diff", {16'd0, diff}, 32'd0);
        check_eq("rst_flags", {30'd0, bout, ovf}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(16'h1234, 16'h0235, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1, 3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), i % 2, 1'b0);
        end

        // Reset while digit 2 is being computed aborts the operation.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_diff",  {16'd0, diff},      32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_pulse", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h4321, 16'h1234, 1'b0, 1, 1'b0);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        // Single-digit instance: result one edge after accept.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; in_valid8 = 1'b1;
        e8.diff = {8'd0, 8'hF0}; e8.bout = 1'b1; e8.ovf = 1'b0;
        sb8_q.push_back(e8);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        check_eq("n1_in_ready_busy", {31'd0, in_ready8}, 32'd0);
        @(negedge clk);
        check_eq("n1_valid", {31'd0, out_valid8}, 32'd1);
        e8 = sb8_q.pop_front();
        check_eq("n1_diff", {24'd0, diff8}, {16'd0, e8.diff});
        check_eq("n1_flags", {30'd0, bout8, ovf8}, {30'd0, e8.bout, e8.ovf});
        @(negedge clk);
        check_eq("n1_consumed", {31'd0, out_valid8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
